// File: rtl/vga_timing_pkg.sv
// Shared VGA/DVI timing constants and sizing helpers for vga_timing_gen.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        logic        pol;
    } axis_mode_t;

    // Standard CEA/VESA modes; pol is the sync level while asserted.
    localparam axis_mode_t MODE_640X480_H   = '{active: 640,  fp: 16,  sync: 96,  bp: 48,  pol: 1'b0};
    localparam axis_mode_t MODE_640X480_V   = '{active: 480,  fp: 10,  sync: 2,   bp: 33,  pol: 1'b0};
    localparam axis_mode_t MODE_800X600_H   = '{active: 800,  fp: 40,  sync: 128, bp: 88,  pol: 1'b1};
    localparam axis_mode_t MODE_800X600_V   = '{active: 600,  fp: 1,   sync: 4,   bp: 23,  pol: 1'b1};
    localparam axis_mode_t MODE_1280X720_H  = '{active: 1280, fp: 110, sync: 40,  bp: 220, pol: 1'b1};
    localparam axis_mode_t MODE_1280X720_V  = '{active: 720,  fp: 5,   sync: 5,   bp: 20,  pol: 1'b1};
    localparam axis_mode_t MODE_1920X1080_H = '{active: 1920, fp: 88,  sync: 44,  bp: 148, pol: 1'b1};
    localparam axis_mode_t MODE_1920X1080_V = '{active: 1080, fp: 4,   sync: 5,   bp: 36,  pol: 1'b1};

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Minimum counter width able to hold 0..total-1.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one video axis with carry and region decode.
module vga_axis_counter #(
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned TOTAL  = 800,
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             carry_c,
    output logic             first_c,
    output logic             active_c,
    output logic             sync_c
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Decode of the current (pre-increment) position.
    always_comb begin
        carry_c  = inc && (cnt == LAST);
        first_c  = (cnt == '0);
        active_c = (cnt < ACT_END);
        sync_c   = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Full-frame VGA/DVI timing generator on a pixel-clock enable.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = MODE_640X480_H.active,
    parameter int unsigned H_FP     = MODE_640X480_H.fp,
    parameter int unsigned H_SYNC   = MODE_640X480_H.sync,
    parameter int unsigned H_BP     = MODE_640X480_H.bp,
    parameter int unsigned V_ACTIVE = MODE_640X480_V.active,
    parameter int unsigned V_FP     = MODE_640X480_V.fp,
    parameter int unsigned V_SYNC   = MODE_640X480_V.sync,
    parameter int unsigned V_BP     = MODE_640X480_V.bp,
    parameter logic        HS_POL   = MODE_640X480_H.pol,
    parameter logic        VS_POL   = MODE_640X480_V.pol,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    if (cnt_width(MAX_TOTAL) > CNT_W) begin : g_width_check
        $error("vga_timing_gen: CNT_W too narrow for the frame totals");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_seg_check
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic h_carry_c, h_first_c, h_active_c, h_sync_c;
    logic v_carry_unused, v_first_c, v_active_c, v_sync_c;
    logic v_inc_c;

    assign v_inc_c = en && h_carry_c;

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .TOTAL (H_TOTAL),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC)
    ) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (en),
        .cnt     (h_cnt),
        .carry_c (h_carry_c),
        .first_c (h_first_c),
        .active_c(h_active_c),
        .sync_c  (h_sync_c)
    );

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .TOTAL (V_TOTAL),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC)
    ) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (v_inc_c),
        .cnt     (v_cnt),
        .carry_c (v_carry_unused),
        .first_c (v_first_c),
        .active_c(v_active_c),
        .sync_c  (v_sync_c)
    );

    // Output stage: decoded from the pre-increment counters, frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hs          <= h_sync_c ? HS_POL : ~HS_POL;
            vs          <= v_sync_c ? VS_POL : ~VS_POL;
            de          <= h_active_c && v_active_c;
            x           <= (h_active_c && v_active_c) ? h_cnt : '0;
            y           <= (h_active_c && v_active_c) ? v_cnt : '0;
            line_start  <= h_first_c;
            frame_start <= h_first_c && v_first_c;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (en && h_first_c && v_first_c) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 14x8 frame.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic hs, vs, de, line_start, frame_start;
    logic [11:0] x, y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .x          (x),
        .y          (y),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          ph;
        logic        hs, vs, de;
        logic [11:0] x, y;
        logic        ls, fs;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t got;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    int   phase = 0;
    logic [15:0] fc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            logic ok;
            got = q.pop_front();
            ok = (got.due == cyc) && (hs === got.hs) && (vs === got.vs) && (de === got.de)
                 && (x === got.x) && (y === got.y) && (line_start === got.ls)
                 && (frame_start === got.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
            ok = ok && (frame_cnt === got.fc);
`endif
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL ph%0d cyc=%0d due=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                         got.ph, cyc, got.due, hs, vs, de, x, y, line_start, frame_start,
                         got.hs, got.vs, got.de, got.x, got.y, got.ls, got.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
                $display("  frame_cnt got=%0d want=%0d", frame_cnt, got.fc);
`endif
            end
        end
    end

    // Drive one clock of stimulus and queue the response expected after the next edge.
    task automatic step(input logic e_in, input logic r_in, input logic wrap);
        int h, v;
        @(negedge clk);
        #1;
        en    = e_in;
        rst_n = r_in;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (wrap) begin
            force dut.frame_cnt = 16'hFFFF;
            release dut.frame_cnt;
            fc = 16'hFFFF;
        end
`else
        if (wrap) fc = fc;
`endif
        if (!r_in) begin
            cur.hs = 1'b1; cur.vs = 1'b0; cur.de = 1'b0;
            cur.x = '0; cur.y = '0; cur.ls = 1'b0; cur.fs = 1'b0;
            k = 0;
            fc = '0;
        end else if (e_in) begin
            k++;
            h = (k - 1) % 14;
            v = ((k - 1) / 14) % 8;
            cur.hs = (h >= 10 && h <= 12) ? 1'b0 : 1'b1;
            cur.vs = (v >= 5 && v <= 6) ? 1'b1 : 1'b0;
            cur.de = (h < 8) && (v < 4);
            cur.x  = cur.de ? 12'(h) : 12'd0;
            cur.y  = cur.de ? 12'(v) : 12'd0;
            cur.ls = (h == 0);
            cur.fs = (h == 0) && (v == 0);
            if (cur.fs) fc = fc + 16'd1;
        end else begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
        end
        cur.fc  = fc;
        cur.due = cyc + 1;
        cur.ph  = phase;
        q.push_back(cur);
    endtask

    initial begin
        // Reset held with en high: sync outputs sit at their idle levels.
        phase = 1;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        // Run to en cycle 49, then reset pulse on en cycle 50.
        phase = 2;
        repeat (49) step(1'b1, 1'b1, 1'b0);
        phase = 5;
        step(1'b1, 1'b0, 1'b0);
        // Three full frames of free run after release.
        phase = 3;
        repeat (336) step(1'b1, 1'b1, 1'b0);
        // Irregular enable pattern.
        phase = 4;
        repeat (300) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        // Preset frame counter and run past the next frame start.
        phase = 6;
        step(1'b1, 1'b1, 1'b1);
        repeat (120) step(1'b1, 1'b1, 1'b0);
        // Drain with a bounded wait.
        repeat (4) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
